alu_op_sequencer: RTL and testbench
===================================

ALU_OP_SEQUENCER -- requirements
Module: alu_op_sequencer

Interface
REQ-001 The block SHALL have one parameter: SETTLE_CYCLES, default 4, cycles between driving operands and sampling ALU result (legal 1..255).
REQ-002 The block SHALL have port clock, input, 1, single rising-edge clock.
REQ-003 The block SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-004 The block SHALL have port cmd_valid, input, 1, command request present.
REQ-005 The block SHALL have port cmd_ready, output, 1, block accepts command this cycle.
REQ-006 The block SHALL have port cmd_select, input, 3, ALU mode code.
REQ-007 The block SHALL have ports cmd_a, cmd_b and cmd_c, input, 4 each, operands A, B and C.
REQ-008 The block SHALL have port alu_select, output, 3, registered drive to ALU Select.
REQ-009 The block SHALL have ports alu_a, alu_b and alu_c, output, 4 each, registered drives to ALU A, B and C.
REQ-010 The block SHALL have ports alu_regout, input, 4, and alu_carryout, input, 1, ALU RegOut and Carryout.
REQ-011 The block SHALL have port rsp_valid, output, 1, captured result available.
REQ-012 The block SHALL have port rsp_ready, input, 1, consumer takes result.
REQ-013 The block SHALL have port rsp_data, output, 4, captured RegOut.
REQ-014 The block SHALL have port rsp_carry, output, 1, captured Carryout.
REQ-015 The block SHALL have port busy, output, 1, high in any state other than IDLE.
REQ-016 The block SHALL have port op_count, output, 8, number of completed responses.

Function
REQ-017 The block SHALL implement a state machine with states IDLE, SETTLE and RESP.
REQ-018 In IDLE, cmd_ready SHALL be 1; in SETTLE and RESP, cmd_ready SHALL be 0.
REQ-019 In IDLE with cmd_valid=1 at a clock edge, the block SHALL latch cmd_select, cmd_a, cmd_b and cmd_c into alu_select, alu_a, alu_b and alu_c, load the settle counter with SETTLE_CYCLES, and enter SETTLE.
REQ-020 alu_select, alu_a, alu_b and alu_c SHALL change only on command acceptance; between commands they SHALL hold the last accepted values.
REQ-021 In SETTLE, each edge with counter > 1 SHALL decrement the counter; cmd_valid SHALL be ignored in SETTLE.
REQ-022 On the SETTLE edge with counter = 1, the block SHALL register alu_regout into rsp_data and alu_carryout into rsp_carry, set rsp_valid=1, and enter RESP.
REQ-023 rsp_valid SHALL therefore rise exactly SETTLE_CYCLES edges after the accept edge; with SETTLE_CYCLES=1, sampling SHALL occur on the first edge after acceptance.
REQ-024 In RESP, rsp_valid, rsp_data and rsp_carry SHALL hold stable until rsp_ready=1 at an edge.
REQ-025 On the RESP edge with rsp_ready=1, the block SHALL clear rsp_valid, increment op_count, and return to IDLE.
REQ-026 op_count SHALL increment modulo 256, wrapping 255 to 0.
REQ-027 rsp_ready asserted outside RESP SHALL have no effect.
REQ-028 rsp_data and rsp_carry SHALL retain their last captured values after the handshake.
REQ-029 The earliest next command accept SHALL be the edge following the RESP handshake edge.
REQ-030 Minimum command-to-command period SHALL be SETTLE_CYCLES+2 cycles.
REQ-031 All eight cmd_select codes SHALL be legal and SHALL be passed through unmodified; the block SHALL not interpret results.

Reset
REQ-032 Assertion of reset SHALL immediately, without a clock edge, force state=IDLE.
REQ-033 Assertion of reset SHALL immediately force the counter to 0.
REQ-034 Assertion of reset SHALL immediately force alu_select, alu_a, alu_b, alu_c, rsp_data, rsp_carry, rsp_valid and op_count to 0.
REQ-035 Reset asserted mid-SETTLE or mid-RESP SHALL discard the in-flight operation and produce no response.
REQ-036 After reset, cmd_ready SHALL be 1 and busy SHALL be 0.
REQ-037 After reset deasserts, the first edge with cmd_valid=1 SHALL be accepted normally.

Verification
REQ-038 The bench SHALL cover: SETTLE_CYCLES=4; bench ALU model returns A AND B; command select=010, A=1100, B=1010 -> rsp_valid rises 4 edges after accept; rsp_data=1000; rsp_carry=0; op_count=1 after handshake.
REQ-039 The bench SHALL cover: select=001, A=1111, B=0001, C=0001, with the model returning A+B+C -> rsp_data=0001; rsp_carry=1.
REQ-040 The bench SHALL cover: rsp_ready held 0 for 10 cycles while alu_regout changes -> rsp_data/rsp_carry stable; cmd_ready=0; a second cmd_valid is not accepted until 1 edge after the handshake.
REQ-041 The bench SHALL cover: reset pulsed 2 cycles after accept -> all outputs 0 asynchronously; no rsp_valid ever; op_count=0.
REQ-042 The bench SHALL cover: 256 back-to-back commands with rsp_ready=1 -> op_count wraps to 0; each period is SETTLE_CYCLES+2 cycles.
REQ-043 The bench SHALL cover: SETTLE_CYCLES=1 -> rsp_valid on the first edge after accept; the result reflects operands latched at accept.

Source files
------------

// File: rtl/alu_op_sequencer.sv
// Sequences one operation at a time onto an external ALU: drives registered
// operands, waits SETTLE_CYCLES edges, captures the result and holds it for a consumer.
module alu_op_sequencer #(
    parameter int unsigned SETTLE_CYCLES = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [2:0] cmd_select,
    input  logic [3:0] cmd_a,
    input  logic [3:0] cmd_b,
    input  logic [3:0] cmd_c,
    output logic [2:0] alu_select,
    output logic [3:0] alu_a,
    output logic [3:0] alu_b,
    output logic [3:0] alu_c,
    input  logic [3:0] alu_regout,
    input  logic       alu_carryout,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [3:0] rsp_data,
    output logic       rsp_carry,
    output logic       busy,
    output logic [7:0] op_count
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        RESP   = 2'd2
    } state_t;

    localparam logic [7:0] SETTLE_CNT = 8'(SETTLE_CYCLES);

    state_t     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [2:0] sel_q, sel_d;
    logic [3:0] a_q, a_d;
    logic [3:0] b_q, b_d;
    logic [3:0] c_q, c_d;
    logic [3:0] data_q, data_d;
    logic       carry_q, carry_d;
    logic       valid_q, valid_d;
    logic [7:0] ops_q, ops_d;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sel_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            c_q     <= '0;
            data_q  <= '0;
            carry_q <= 1'b0;
            valid_q <= 1'b0;
            ops_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sel_q   <= sel_d;
            a_q     <= a_d;
            b_q     <= b_d;
            c_q     <= c_d;
            data_q  <= data_d;
            carry_q <= carry_d;
            valid_q <= valid_d;
            ops_q   <= ops_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sel_d   = sel_q;
        a_d     = a_q;
        b_d     = b_q;
        c_d     = c_q;
        data_d  = data_q;
        carry_d = carry_q;
        valid_d = valid_q;
        ops_d   = ops_q;
        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    sel_d   = cmd_select;
                    a_d     = cmd_a;
                    b_d     = cmd_b;
                    c_d     = cmd_c;
                    cnt_d   = SETTLE_CNT;
                    state_d = SETTLE;
                end
            end
            SETTLE: begin
                // Capture on the edge where the count reaches 1, so the result
                // is sampled exactly SETTLE_CYCLES edges after acceptance.
                if (cnt_q > 8'd1) begin
                    cnt_d = cnt_q - 8'd1;
                end else begin
                    data_d  = alu_regout;
                    carry_d = alu_carryout;
                    valid_d = 1'b1;
                    state_d = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    valid_d = 1'b0;
                    ops_d   = ops_q + 8'd1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign cmd_ready  = (state_q == IDLE);
    assign busy       = (state_q != IDLE);
    assign alu_select = sel_q;
    assign alu_a      = a_q;
    assign alu_b      = b_q;
    assign alu_c      = c_q;
    assign rsp_valid  = valid_q;
    assign rsp_data   = data_q;
    assign rsp_carry  = carry_q;
    assign op_count   = ops_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: one instance with SETTLE_CYCLES=4 and one with
// SETTLE_CYCLES=1, each driving a behavioural ALU.
module tb_alu_op_sequencer;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic       reset, cmd_valid, cmd_ready, rsp_valid, rsp_ready, rsp_carry, busy;
    logic [2:0] cmd_select, alu_select;
    logic [3:0] cmd_a, cmd_b, cmd_c, alu_a, alu_b, alu_c, alu_regout, rsp_data;
    logic       alu_carryout;
    logic [7:0] op_count;

    logic       reset1, cmd_valid1, cmd_ready1, rsp_valid1, rsp_ready1, rsp_carry1, busy1;
    logic [2:0] cmd_select1, alu_select1;
    logic [3:0] cmd_a1, cmd_b1, cmd_c1, alu_a1, alu_b1, alu_c1, alu_regout1, rsp_data1;
    logic       alu_carryout1;
    logic [7:0] op_count1;

    logic [3:0] pert;
    logic       pert_c;

    function automatic logic [4:0] alu_model(input logic [2:0] s, input logic [3:0] a,
                                             input logic [3:0] b, input logic [3:0] c);
        case (s)
            3'b000:  return {1'b0, a | b};
            3'b001:  return 5'(a) + 5'(b) + 5'(c);
            3'b010:  return {1'b0, a & b};
            3'b011:  return {1'b0, a ^ b};
            3'b100:  return {1'b0, ~a};
            3'b101:  return 5'(a) + 5'(b);
            3'b110:  return {1'b0, c};
            default: return {1'b0, b};
        endcase
    endfunction

    logic [4:0] m, m1;
    assign m             = alu_model(alu_select, alu_a, alu_b, alu_c);
    assign alu_regout    = m[3:0] ^ pert;
    assign alu_carryout  = m[4] ^ pert_c;
    assign m1            = alu_model(alu_select1, alu_a1, alu_b1, alu_c1);
    assign alu_regout1   = m1[3:0];
    assign alu_carryout1 = m1[4];

    alu_op_sequencer #(.SETTLE_CYCLES(4)) dut (
        .clock(clock), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_select(cmd_select), .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_c(cmd_c),
        .alu_select(alu_select), .alu_a(alu_a), .alu_b(alu_b), .alu_c(alu_c),
        .alu_regout(alu_regout), .alu_carryout(alu_carryout),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_carry(rsp_carry), .busy(busy), .op_count(op_count)
    );

    alu_op_sequencer #(.SETTLE_CYCLES(1)) dut1 (
        .clock(clock), .reset(reset1), .cmd_valid(cmd_valid1), .cmd_ready(cmd_ready1),
        .cmd_select(cmd_select1), .cmd_a(cmd_a1), .cmd_b(cmd_b1), .cmd_c(cmd_c1),
        .alu_select(alu_select1), .alu_a(alu_a1), .alu_b(alu_b1), .alu_c(alu_c1),
        .alu_regout(alu_regout1), .alu_carryout(alu_carryout1),
        .rsp_valid(rsp_valid1), .rsp_ready(rsp_ready1), .rsp_data(rsp_data1),
        .rsp_carry(rsp_carry1), .busy(busy1), .op_count(op_count1)
    );

    typedef struct {
        logic [2:0] sel;
        logic [3:0] a, b, c;
        logic [3:0] exp_data;
        logic       exp_carry;
    } vec_t;

    vec_t       vecs[8];
    int         passed = 0;
    int         total  = 0;
    logic [7:0] exp_ops = 8'd0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp)
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        else
            passed++;
    endtask

    task automatic wait_rsp(output int lat);
        lat = 0;
        while (rsp_valid !== 1'b1 && lat < 300) begin
            @(negedge clock);
            lat++;
        end
    endtask

    task automatic run_cmd(input logic [2:0] s, input logic [3:0] a, input logic [3:0] b,
                           input logic [3:0] c, output int lat);
        @(negedge clock);
        check("cmd_ready_idle", 32'(cmd_ready), 32'd1);
        cmd_valid  = 1'b1;
        cmd_select = s;
        cmd_a      = a;
        cmd_b      = b;
        cmd_c      = c;
        @(negedge clock);
        cmd_valid = 1'b0;
        wait_rsp(lat);
    endtask

    task automatic handshake();
        rsp_ready = 1'b1;
        @(negedge clock);
        rsp_ready = 1'b0;
        exp_ops++;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, got running expected finished");
        $fatal(1);
    end

    initial begin
        int lat, unstable, seen, accepts, last, bad, cyc;

        vecs[0] = '{3'b010, 4'b1100, 4'b1010, 4'b0000, 4'b1000, 1'b0};
        vecs[1] = '{3'b001, 4'b1111, 4'b0001, 4'b0001, 4'b0001, 1'b1};
        vecs[2] = '{3'b000, 4'b0101, 4'b0010, 4'b0000, 4'b0111, 1'b0};
        vecs[3] = '{3'b011, 4'b1100, 4'b0110, 4'b0000, 4'b1010, 1'b0};
        vecs[4] = '{3'b100, 4'b0011, 4'b0000, 4'b0000, 4'b1100, 1'b0};
        vecs[5] = '{3'b101, 4'b1001, 4'b1000, 4'b0000, 4'b0001, 1'b1};
        vecs[6] = '{3'b110, 4'b0000, 4'b0000, 4'b1011, 4'b1011, 1'b0};
        vecs[7] = '{3'b111, 4'b0000, 4'b0110, 4'b0000, 4'b0110, 1'b0};

        reset = 1'b1; reset1 = 1'b1;
        cmd_valid = 1'b0; rsp_ready = 1'b0; cmd_select = '0; cmd_a = '0; cmd_b = '0; cmd_c = '0;
        cmd_valid1 = 1'b0; rsp_ready1 = 1'b0; cmd_select1 = '0; cmd_a1 = '0; cmd_b1 = '0; cmd_c1 = '0;
        pert = '0; pert_c = 1'b0;

        #1;
        check("reset_cmd_ready", 32'(cmd_ready), 32'd1);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_outputs", 32'({alu_select, alu_a, alu_b, alu_c, rsp_data, rsp_carry, rsp_valid}), 32'd0);
        check("reset_op_count", 32'(op_count), 32'd0);
        @(negedge clock);
        reset = 1'b0; reset1 = 1'b0;

        // rsp_ready outside RESP is ignored
        rsp_ready = 1'b1;
        repeat (2) @(negedge clock);
        rsp_ready = 1'b0;
        check("idle_rsp_ready_op_count", 32'(op_count), 32'd0);
        check("idle_rsp_ready_busy", 32'(busy), 32'd0);

        for (int i = 0; i < 8; i++) begin
            run_cmd(vecs[i].sel, vecs[i].a, vecs[i].b, vecs[i].c, lat);
            check("latency", 32'(lat), 32'd4);
            check("alu_select", 32'(alu_select), 32'(vecs[i].sel));
            check("alu_operands", 32'({alu_a, alu_b, alu_c}), 32'({vecs[i].a, vecs[i].b, vecs[i].c}));
            check("rsp_data", 32'(rsp_data), 32'(vecs[i].exp_data));
            check("rsp_carry", 32'(rsp_carry), 32'(vecs[i].exp_carry));
            check("busy_resp", 32'(busy), 32'd1);
            handshake();
            check("rsp_valid_cleared", 32'(rsp_valid), 32'd0);
            check("op_count", 32'(op_count), 32'(exp_ops));
            check("rsp_data_retained", 32'({rsp_data, rsp_carry}), 32'({vecs[i].exp_data, vecs[i].exp_carry}));
        end

        // Consumer stall while ALU output wiggles and a new command waits
        run_cmd(3'b011, 4'b1001, 4'b0011, 4'b0000, lat);
        check("stall_latency", 32'(lat), 32'd4);
        check("stall_rsp_data", 32'(rsp_data), 32'b1010);
        cmd_valid = 1'b1; cmd_select = 3'b010; cmd_a = 4'b0110; cmd_b = 4'b0111; cmd_c = 4'b0001;
        unstable = 0;
        for (int k = 0; k < 10; k++) begin
            pert   = 4'(k + 1);
            pert_c = k[0];
            @(negedge clock);
            if (rsp_data !== 4'b1010 || rsp_carry !== 1'b0 || rsp_valid !== 1'b1 ||
                cmd_ready !== 1'b0 || alu_a !== 4'b1001)
                unstable++;
        end
        check("stall_stable_cycles_bad", 32'(unstable), 32'd0);
        pert = '0; pert_c = 1'b0;
        handshake();
        check("stall_hs_rsp_valid", 32'(rsp_valid), 32'd0);
        check("stall_no_accept_on_hs", 32'(alu_a), 32'b1001);
        check("stall_cmd_ready_after_hs", 32'(cmd_ready), 32'd1);
        check("stall_op_count", 32'(op_count), 32'(exp_ops));
        @(negedge clock);
        cmd_valid = 1'b0;
        check("accept_after_hs", 32'({alu_select, alu_a, alu_b}), 32'({3'b010, 4'b0110, 4'b0111}));
        check("busy_after_accept", 32'(busy), 32'd1);
        wait_rsp(lat);
        check("second_latency", 32'(lat), 32'd4);
        check("second_rsp", 32'({rsp_data, rsp_carry}), 32'({4'b0110, 1'b0}));
        handshake();

        // Reset two edges into SETTLE
        @(negedge clock);
        cmd_valid = 1'b1; cmd_select = 3'b101; cmd_a = 4'b1111; cmd_b = 4'b1111; cmd_c = 4'b0000;
        @(negedge clock);
        cmd_valid = 1'b0;
        repeat (2) @(negedge clock);
        #2 reset = 1'b1;
        #1;
        check("async_reset_alu", 32'({alu_select, alu_a, alu_b, alu_c}), 32'd0);
        check("async_reset_rsp", 32'({rsp_data, rsp_carry, rsp_valid}), 32'd0);
        check("async_reset_op_count", 32'(op_count), 32'd0);
        check("async_reset_ready_busy", 32'({cmd_ready, busy}), 32'b10);
        @(negedge clock);
        reset = 1'b0;
        exp_ops = 8'd0;
        seen = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clock);
            if (rsp_valid !== 1'b0) seen++;
        end
        check("no_rsp_after_reset", 32'(seen), 32'd0);
        check("op_count_after_reset", 32'(op_count), 32'd0);

        // 256 back-to-back commands
        cmd_valid = 1'b1; rsp_ready = 1'b1; cmd_select = 3'b010; cmd_a = 4'b1100; cmd_b = 4'b1010;
        accepts = 0; last = -1; bad = 0; cyc = 0;
        while (accepts < 256 && cyc < 5000) begin
            if (cmd_ready === 1'b1) begin
                if (last >= 0 && cyc - last != 6) bad++;
                last = cyc;
                accepts++;
            end
            @(negedge clock);
            cyc++;
        end
        cmd_valid = 1'b0;
        check("wrap_accepts", 32'(accepts), 32'd256);
        check("wrap_period_bad", 32'(bad), 32'd0);
        check("op_count_255", 32'(op_count), 32'd255);
        cyc = 0;
        while (busy !== 1'b0 && cyc < 50) begin
            @(negedge clock);
            cyc++;
        end
        rsp_ready = 1'b0;
        check("op_count_wrap", 32'(op_count), 32'd0);

        // SETTLE_CYCLES = 1 instance
        @(negedge clock);
        check("s1_cmd_ready", 32'(cmd_ready1), 32'd1);
        cmd_valid1 = 1'b1; cmd_select1 = 3'b010; cmd_a1 = 4'b1100; cmd_b1 = 4'b1010; cmd_c1 = 4'b0000;
        @(negedge clock);
        cmd_valid1 = 1'b0; cmd_select1 = 3'b000; cmd_a1 = 4'b0011; cmd_b1 = 4'b0101;
        check("s1_not_yet_valid", 32'(rsp_valid1), 32'd0);
        @(negedge clock);
        check("s1_valid_first_edge", 32'(rsp_valid1), 32'd1);
        check("s1_rsp", 32'({rsp_data1, rsp_carry1}), 32'({4'b1000, 1'b0}));
        check("s1_latched_ops", 32'({alu_select1, alu_a1, alu_b1}), 32'({3'b010, 4'b1100, 4'b1010}));
        rsp_ready1 = 1'b1;
        @(negedge clock);
        rsp_ready1 = 1'b0;
        check("s1_op_count", 32'(op_count1), 32'd1);
        check("s1_idle", 32'({busy1, cmd_ready1, rsp_valid1}), 32'b010);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
